// File: rtl/drc_hpxl_packer.sv
// Half-pixel to DMA word packer: gathers DVP bytes into OUT_DATA_W words with
// strobes/last, optional per-pixel byte swap, and per-frame word/parity status.
module drc_hpxl_packer #(
    parameter int DVP_DATA_W = 8,
    parameter int OUT_DATA_W = 32,
    parameter int BYTE_NUM   = OUT_DATA_W / DVP_DATA_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DVP_DATA_W-1:0] bwd_hpxl_dat,
    input  logic                  bwd_hpxl_last,
    input  logic                  bwd_hpxl_vld,
    output logic                  bwd_hpxl_rdy,
    output logic [OUT_DATA_W-1:0] fwd_dma_dat,
    output logic [BYTE_NUM-1:0]   fwd_dma_strb,
    output logic                  fwd_dma_last,
    output logic                  fwd_dma_vld,
    input  logic                  fwd_dma_rdy,
    input  logic                  cfg_byte_swap,
    output logic [CNT_W-1:0]      frm_word_cnt,
    output logic                  frm_done,
    output logic                  frm_odd_err
);
    localparam int LW = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

    logic [LW-1:0]         lane_cnt;
    logic [LW-1:0]         lane;
    logic                  swap_q;
    logic                  swap_eff;
    logic [OUT_DATA_W-1:0] pack_dat;
    logic [BYTE_NUM-1:0]   pack_strb;
    logic [OUT_DATA_W-1:0] word_dat;
    logic [BYTE_NUM-1:0]   word_strb;
    logic                  hp_parity;
    logic                  out_vld_q;
    logic                  bwd_hsk;
    logic                  fwd_hsk;
    logic                  word_close;

    assign bwd_hpxl_rdy = ~out_vld_q | fwd_dma_rdy;
    assign fwd_dma_vld  = out_vld_q;
    assign bwd_hsk      = bwd_hpxl_vld & bwd_hpxl_rdy;
    assign fwd_hsk      = out_vld_q & fwd_dma_rdy;
    assign word_close   = bwd_hsk & ((lane_cnt == LW'(BYTE_NUM - 1)) | bwd_hpxl_last);

    // Swap is latched at the first lane so a word never mixes two lane orders.
    assign swap_eff = (lane_cnt == '0) ? cfg_byte_swap : swap_q;
    assign lane     = lane_cnt ^ LW'(swap_eff);

    always_comb begin
        word_dat  = pack_dat;
        word_strb = pack_strb;
        word_dat[lane*DVP_DATA_W +: DVP_DATA_W] = bwd_hpxl_dat;
        word_strb[lane] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt  <= '0;
            pack_dat  <= '0;
            pack_strb <= '0;
            swap_q    <= 1'b0;
            hp_parity <= 1'b0;
        end else if (bwd_hsk) begin
            if (lane_cnt == '0)
                swap_q <= cfg_byte_swap;
            hp_parity <= bwd_hpxl_last ? 1'b0 : ~hp_parity;
            if (word_close) begin
                lane_cnt  <= '0;
                pack_dat  <= '0;
                pack_strb <= '0;
            end else begin
                lane_cnt  <= lane_cnt + LW'(1);
                pack_dat  <= word_dat;
                pack_strb <= word_strb;
            end
        end
    end

    // A close in the same cycle as a drain reloads, keeping one byte per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q    <= 1'b0;
            fwd_dma_dat  <= '0;
            fwd_dma_strb <= '0;
            fwd_dma_last <= 1'b0;
        end else if (word_close) begin
            out_vld_q    <= 1'b1;
            fwd_dma_dat  <= word_dat;
            fwd_dma_strb <= word_strb;
            fwd_dma_last <= bwd_hpxl_last;
        end else if (fwd_hsk) begin
            out_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_word_cnt <= '0;
            frm_done     <= 1'b0;
            frm_odd_err  <= 1'b0;
        end else begin
            frm_done    <= fwd_hsk & fwd_dma_last;
            frm_odd_err <= bwd_hsk & bwd_hpxl_last & ~hp_parity;
            if (fwd_hsk)
                frm_word_cnt <= fwd_dma_last ? '0 : frm_word_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_drc_hpxl_packer.sv
// Randomized bench for drc_hpxl_packer against a byte-queue reference model.
module tb_drc_hpxl_packer;
    localparam int BN = 4;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  strb;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bwd_hpxl_dat = '0;
    logic        bwd_hpxl_last = 1'b0;
    logic        bwd_hpxl_vld = 1'b0;
    logic        bwd_hpxl_rdy;
    logic [31:0] fwd_dma_dat;
    logic [3:0]  fwd_dma_strb;
    logic        fwd_dma_last;
    logic        fwd_dma_vld;
    logic        fwd_dma_rdy = 1'b0;
    logic        cfg_byte_swap = 1'b0;
    logic [15:0] frm_word_cnt;
    logic        frm_done;
    logic        frm_odd_err;

    always #5 clk = ~clk;

    drc_hpxl_packer dut (
        .clk(clk), .rst(rst),
        .bwd_hpxl_dat(bwd_hpxl_dat), .bwd_hpxl_last(bwd_hpxl_last),
        .bwd_hpxl_vld(bwd_hpxl_vld), .bwd_hpxl_rdy(bwd_hpxl_rdy),
        .fwd_dma_dat(fwd_dma_dat), .fwd_dma_strb(fwd_dma_strb),
        .fwd_dma_last(fwd_dma_last), .fwd_dma_vld(fwd_dma_vld),
        .fwd_dma_rdy(fwd_dma_rdy), .cfg_byte_swap(cfg_byte_swap),
        .frm_word_cnt(frm_word_cnt), .frm_done(frm_done), .frm_odd_err(frm_odd_err)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    word_t       expq[$];
    word_t       got_q[$];
    logic [7:0]  cur_b[$];
    bit          cur_swap;
    int          frame_hp = 0;
    logic [15:0] exp_cnt = '0;
    bit          exp_done = 0;
    bit          exp_odd = 0;
    int          n_done_seen = 0;
    int          n_odd_seen = 0;
    int          rdy_pct = 100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick_rdy();
        return $urandom_range(99) < rdy_pct;
    endfunction

    // Reference: collect bytes of the open word, place byte i at lane i^swap.
    task automatic model_accept(input logic [7:0] d, input bit l, input bit sw, output bit odd_n);
        word_t w;
        odd_n = 0;
        if (cur_b.size() == 0) cur_swap = sw;
        cur_b.push_back(d);
        frame_hp++;
        if (cur_b.size() == BN || l) begin
            w = '0;
            for (int i = 0; i < cur_b.size(); i++) begin
                int ln;
                ln = i ^ int'(cur_swap);
                w.dat[ln*8 +: 8] = cur_b[i];
                w.strb[ln] = 1'b1;
            end
            w.last = l;
            expq.push_back(w);
            cur_b.delete();
        end
        if (l) begin
            odd_n = (frame_hp % 2) == 1;
            frame_hp = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit sw,
                         input bit drdy, input bit r, output bit acc);
        bit done_n, odd_n;
        word_t w;
        @(negedge clk);
        rst = r; bwd_hpxl_vld = v; bwd_hpxl_dat = d; bwd_hpxl_last = l;
        cfg_byte_swap = sw; fwd_dma_rdy = drdy;
        #1;
        acc = 0; done_n = 0; odd_n = 0;
        chk("vld", fwd_dma_vld, expq.size() != 0);
        chk("bwd_rdy", bwd_hpxl_rdy, expq.size() == 0 || drdy);
        chk("word_cnt", frm_word_cnt, exp_cnt);
        chk("frm_done", frm_done, exp_done);
        chk("odd_err", frm_odd_err, exp_odd);
        if (frm_done) n_done_seen++;
        if (frm_odd_err) n_odd_seen++;
        if (fwd_dma_vld && expq.size() != 0) begin
            chk("dat", fwd_dma_dat, expq[0].dat);
            chk("strb", fwd_dma_strb, expq[0].strb);
            chk("last", fwd_dma_last, expq[0].last);
        end
        if (!r) begin
            if (fwd_dma_vld && fwd_dma_rdy && expq.size() != 0) begin
                w = expq.pop_front();
                got_q.push_back({fwd_dma_dat, fwd_dma_strb, fwd_dma_last});
                if (w.last) begin exp_cnt = '0; done_n = 1; end
                else exp_cnt = exp_cnt + 16'd1;
            end
            if (bwd_hpxl_vld && bwd_hpxl_rdy) begin
                acc = 1;
                model_accept(d, l, sw, odd_n);
            end
        end else begin
            expq.delete(); cur_b.delete(); frame_hp = 0; exp_cnt = '0;
        end
        exp_done = done_n; exp_odd = odd_n;
    endtask

    task automatic send(input logic [7:0] d, input bit l, input bit sw);
        bit acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, d, l, sw, pick_rdy(), 1'b0, acc);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("hsk_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, pick_rdy(), 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin idle(1); n++; end
        if (expq.size() != 0) chk("drain_timeout", 0, 1);
        idle(2);
    endtask

    task automatic do_reset();
        bit acc;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_vld", fwd_dma_vld, 0);
        chk("rst_dat", fwd_dma_dat, 0);
        chk("rst_strb", fwd_dma_strb, 0);
        chk("rst_last", fwd_dma_last, 0);
        chk("rst_cnt", frm_word_cnt, 0);
        chk("rst_done", frm_done, 0);
        chk("rst_odd", frm_odd_err, 0);
        chk("rst_rdy", bwd_hpxl_rdy, 1);
    endtask

    initial begin
        int d0, o0, nbytes;
        logic [7:0] v;
        do_reset();

        // Plain 8-byte frame
        rdy_pct = 100; got_q.delete(); d0 = n_done_seen;
        for (int i = 1; i <= 8; i++) begin v = 8'(i * 8'h11); send(v, i == 8, 1'b0); end
        drain();
        chk("t1_nwords", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t1_w0", got_q[0], {32'h44332211, 4'hF, 1'b0});
            chk("t1_w1", got_q[1], {32'h88776655, 4'hF, 1'b1});
        end
        chk("t1_done_pulses", n_done_seen - d0, 1);
        chk("t1_cnt_after", frm_word_cnt, 0);

        // Byte swap
        got_q.delete();
        send(8'hA1, 0, 1); send(8'hB2, 0, 1); send(8'hC3, 0, 1); send(8'hD4, 1, 1);
        drain();
        if (got_q.size() == 1) chk("t2_w0", got_q[0], {32'hC3D4A1B2, 4'hF, 1'b1});
        else chk("t2_nwords", got_q.size(), 1);

        // Six-byte frame, partial last word, even count
        got_q.delete(); o0 = n_odd_seen;
        for (int i = 1; i <= 6; i++) send(8'(i), i == 6, 1'b0);
        drain();
        chk("t3_nwords", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t3_w0", got_q[0], {32'h04030201, 4'hF, 1'b0});
            chk("t3_w1", got_q[1], {32'h00000605, 4'h3, 1'b1});
        end
        chk("t3_no_odd", n_odd_seen - o0, 0);

        // Odd frame
        got_q.delete(); o0 = n_odd_seen;
        send(8'h10, 0, 0); send(8'h20, 0, 0); send(8'h30, 1, 0);
        drain();
        if (got_q.size() == 1) chk("t5_w0", got_q[0], {32'h00302010, 4'h7, 1'b1});
        else chk("t5_nwords", got_q.size(), 1);
        chk("t5_odd_pulses", n_odd_seen - o0, 1);

        // Single byte with swap lands in lane 1
        got_q.delete();
        send(8'h5A, 1, 1);
        drain();
        if (got_q.size() == 1) chk("t6_w0", got_q[0], {32'h00005A00, 4'h2, 1'b1});
        else chk("t6_nwords", got_q.size(), 1);

        // Backpressure: word stalls 5 cycles, then random stream with random rdy
        rdy_pct = 0;
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 0, 0);
        idle(5);
        got_q.delete();
        rdy_pct = 60; nbytes = 0;
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            send(v, (i == 63) || ($urandom_range(15) == 0), 1'($urandom));
        end
        drain();
        foreach (got_q[i]) nbytes += $countones(got_q[i].strb);
        chk("t4_bytes", nbytes, 68);

        // Reset mid-stall, then mid-frame
        rdy_pct = 100;
        for (int i = 0; i < 4; i++) send(8'(8'h90 + i), 0, 0);
        idle(2);
        rdy_pct = 0;
        for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 0, 0);
        idle(3);
        do_reset();
        rdy_pct = 100;
        send(8'h55, 0, 0); send(8'h66, 0, 0);
        do_reset();
        got_q.delete();
        for (int i = 0; i < 4; i++) send(8'(8'hE0 + i), i == 3, 0);
        drain();
        if (got_q.size() == 1) chk("t7_w0", got_q[0], {32'hE3E2E1E0, 4'hF, 1'b1});
        else chk("t7_nwords", got_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/drc_hpxl_packer.md
Name: drc_hpxl_packer

Overview:
- Sits directly downstream of the DRC capture state machine and consumes its half-pixel stream (8-bit DVP bytes plus frame-last flag).
- Packs consecutive half-pixels into OUT_DATA_W-wide words with byte strobes and a last flag for the DMA write channel.
- Optionally swaps bytes within each 16-bit pixel, and reports per-frame word count, frame completion and odd-length frames.

Parameters:
- DVP_DATA_W, 8, width of one half-pixel.
- OUT_DATA_W, 32, DMA word width; must be an integer multiple of 2*DVP_DATA_W.
- BYTE_NUM, OUT_DATA_W/DVP_DATA_W, lanes per word (derived).
- CNT_W, 16, width of the frame word counter.

Ports:
- clk  input  1  sole clock.
- rst  input  1  reset; synchronous, active-high.
- bwd_hpxl_dat  input  DVP_DATA_W  half-pixel data from the capture stage.
- bwd_hpxl_last  input  1  half-pixel is the final one of the frame.
- bwd_hpxl_vld  input  1  half-pixel valid.
- bwd_hpxl_rdy  output  1  half-pixel accepted.
- fwd_dma_dat  output  OUT_DATA_W  packed word.
- fwd_dma_strb  output  BYTE_NUM  lane i holds valid data.
- fwd_dma_last  output  1  final word of the frame.
- fwd_dma_vld  output  1  word valid.
- fwd_dma_rdy  input  1  DMA accepts word.
- cfg_byte_swap  input  1  1 = swap the two bytes of each pixel.
- frm_word_cnt  output  CNT_W  words handshaken in current frame.
- frm_done  output  1  one-cycle pulse on last-word handshake.
- frm_odd_err  output  1  one-cycle pulse when a frame ends on an odd half-pixel count.

Behaviour:
- In-handshake: bwd_hsk = bwd_hpxl_vld & bwd_hpxl_rdy. Out-handshake: fwd_hsk = fwd_dma_vld & fwd_dma_rdy.
- bwd_hpxl_rdy = ~out_vld_q | fwd_dma_rdy. There is no combinational path from bwd_hpxl_vld to bwd_hpxl_rdy.
- Pack register: lane_cnt (0..BYTE_NUM-1), pack_dat, pack_strb, hp_parity (half-pixel count mod 2 within the frame).
- Lane mapping:
  - On bwd_hsk the byte goes to lane L = lane_cnt ^ cfg_byte_swap (LSB flip). Lane 0 is bits [DVP_DATA_W-1:0].
  - pack_strb[L] is set.
  - cfg_byte_swap is sampled only while lane_cnt == 0 and held until the word closes.
- Word close: on bwd_hsk when lane_cnt == BYTE_NUM-1 or bwd_hpxl_last == 1.
  - The completed word (including the current byte) loads the output register: out_vld_q = 1, fwd_dma_last = bwd_hpxl_last.
  - lane_cnt, pack_dat and pack_strb clear to 0 in the same cycle.
  - Latency from the closing half-pixel handshake to fwd_dma_vld is 1 cycle.
- Otherwise, on bwd_hsk: lane_cnt increments and the output register is untouched.
- Output register:
  - Cleared (out_vld_q = 0) on fwd_hsk unless reloaded in the same cycle.
  - A simultaneous fwd_hsk and word close reloads it with the new word, giving full throughput of 1 half-pixel/cycle.
- Partial last word: unused lanes carry data 0 and strb 0. With byte swap and an odd count, the strobe reflects the swapped lane that was actually written. Example: a single byte with swap gives strb 4'b0010.
- Holding: while fwd_dma_vld = 1 and fwd_dma_rdy = 0, fwd_dma_dat, fwd_dma_strb and fwd_dma_last are stable.
- frm_word_cnt:
  - Increments on each fwd_hsk and wraps at 2^CNT_W.
  - On a fwd_hsk with fwd_dma_last it resets to 0 in the same cycle, and frm_done pulses for 1 cycle.
- hp_parity toggles on each bwd_hsk and clears on bwd_hsk with last. frm_odd_err pulses 1 cycle after a last handshake at which the post-increment count is odd.
- Reset (rst = 1 at a clk edge, including mid-frame or mid-stall):
  - All state clears: lane_cnt = 0, pack register = 0, out_vld_q = 0.
  - Outputs: fwd_dma_dat = 0, fwd_dma_strb = 0, fwd_dma_last = 0, fwd_dma_vld = 0, frm_word_cnt = 0, frm_done = 0, frm_odd_err = 0.
  - bwd_hpxl_rdy = 1 after reset. Partially packed data is discarded.
- A last flag arriving at lane_cnt == 0 produces a 1-byte word; strb is 4'b0001 without swap.

Test Plan:
- No swap, rdy = 1, stream 0x11,0x22,…,0x88 with last on 0x88 → 2 words: 0x44332211 (strb F, last 0) then 0x88776655 (strb F, last 1). frm_done pulses once, then frm_word_cnt = 0.
- cfg_byte_swap = 1, bytes 0xA1,0xB2,0xC3,0xD4 with last → word 0xC3D4A1B2, strb F, last 1.
- Six bytes 0x01..0x06 with last on 0x06, no swap → 0x04030201 (F), then 0x00000605 (strb 4'b0011, last 1). frm_odd_err stays 0.
- Backpressure: fwd_dma_rdy = 0 for 5 cycles with a word pending → bwd_hpxl_rdy = 0, fwd_dma_dat stable. On release, one word per 4 input cycles continues with no byte lost or duplicated over 64 random bytes.
- Odd frame: 3 bytes 0x10,0x20,0x30 with last → word 0x00302010, strb 4'b0111, frm_odd_err pulses 1 cycle.
- Assert rst for 1 cycle after 2 of 4 lanes are filled and a word is stalled → next cycle fwd_dma_vld = 0, frm_word_cnt = 0. Next 4 bytes 0xE0..0xE3 → 0xE3E2E1E0 with no stale lanes.
